// File: rtl/cpu_seq_pkg.sv
// Shared encodings for the accumulator CPU sequencer: opcodes, address select, FSM states.
// Optional macro CPU_SEQ_STEP_EN adds the single-step PAUSE state.
package cpu_seq_pkg;

   localparam logic [2:0] OP_HLT = 3'd0;
   localparam logic [2:0] OP_SKZ = 3'd1;
   localparam logic [2:0] OP_ADD = 3'd2;
   localparam logic [2:0] OP_AND = 3'd3;
   localparam logic [2:0] OP_XOR = 3'd4;
   localparam logic [2:0] OP_LDA = 3'd5;
   localparam logic [2:0] OP_STO = 3'd6;
   localparam logic [2:0] OP_JMP = 3'd7;

   localparam logic ADDR_PC  = 1'b0;
   localparam logic ADDR_OPR = 1'b1;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_FETCH,
      ST_DECODE,
      ST_OPRD,
      ST_WRITE,
      ST_EXEC,
      ST_HALTED
`ifdef CPU_SEQ_STEP_EN
      , ST_PAUSE
`endif
   } state_t;

   function automatic state_t decode_next(input logic [2:0] op);
      case (op)
         OP_HLT:                         return ST_HALTED;
         OP_SKZ, OP_JMP:                 return ST_EXEC;
         OP_ADD, OP_AND, OP_XOR, OP_LDA: return ST_OPRD;
         OP_STO:                         return ST_WRITE;
         default:                        return ST_HALTED;
      endcase
   endfunction

   // HLT and JMP leave PC alone in DECODE; everything else steps past the opcode byte.
   function automatic logic decode_pc_inc(input logic [2:0] op);
      return (op != OP_HLT) && (op != OP_JMP);
   endfunction

endpackage

// File: rtl/mem_timeout_ctr.sv
// Counts consecutive stalled memory cycles (req without ack); pulses expire on the last allowed one.
// TIMEOUT_CYC = 0 disables the watchdog entirely.
module mem_timeout_ctr #(
   parameter int TIMEOUT_CYC = 15
) (
   input  logic clk,
   input  logic rst,
   input  logic mem_req,
   input  logic mem_ack,
   output logic expire
);

   localparam int CW = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);

   generate
      if (TIMEOUT_CYC == 0) begin : g_off
         assign expire = 1'b0;
      end else begin : g_on
         localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);
         logic [CW-1:0] cnt_reg;
         logic          stall;

         // An ack in the would-be expiry cycle is not a stall, so the ack wins.
         assign stall  = mem_req && !mem_ack;
         assign expire = stall && (cnt_reg == LAST);

         always_ff @(posedge clk) begin
            if (rst || !stall || expire) begin
               cnt_reg <= '0;
            end else begin
               cnt_reg <= cnt_reg + 1'b1;
            end
         end
      end
   endgenerate

endmodule

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle control FSM for the 8-bit accumulator CPU (fetch/decode/operand/store/exec).
// Define CPU_SEQ_STEP_EN to add dbg_en/step inputs and a PAUSE state after each instruction.
module cpu_seq_ctrl
   import cpu_seq_pkg::*;
#(
   parameter int OPW         = 3,
   parameter int TIMEOUT_CYC = 15
) (
   input  logic           clk,
   input  logic           rst,
   input  logic [OPW-1:0] opcode,
   input  logic           ac_zero,
   input  logic           mem_ack,
`ifdef CPU_SEQ_STEP_EN
   input  logic           dbg_en,
   input  logic           step,
`endif
   output logic           mem_req,
   output logic           mem_we,
   output logic           addr_sel,
   output logic           ir_ld,
   output logic           pc_inc,
   output logic           pc_ld,
   output logic           ac_ld,
   output logic           instr_done,
   output logic           halt,
   output logic           bus_err
);

   state_t     state_reg;
   logic       jmp_reg;
   logic       bus_err_reg;
   logic       expire;
   logic [2:0] op;
   state_t     done_next;

   assign op = 3'(opcode);

`ifdef CPU_SEQ_STEP_EN
   assign done_next = dbg_en ? ST_PAUSE : ST_FETCH;
`else
   assign done_next = ST_FETCH;
`endif

   mem_timeout_ctr #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .rst    (rst),
      .mem_req(mem_req),
      .mem_ack(mem_ack),
      .expire (expire)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg   <= ST_IDLE;
         jmp_reg     <= 1'b0;
         bus_err_reg <= 1'b0;
      end else if (expire) begin
         state_reg   <= ST_HALTED;
         bus_err_reg <= 1'b1;
      end else begin
         case (state_reg)
            ST_IDLE:   state_reg <= ST_FETCH;
            ST_FETCH:  if (mem_ack) state_reg <= ST_DECODE;
            ST_DECODE: begin
               // Opcode is only trusted here; EXEC keeps its own copy of the JMP/SKZ choice.
               state_reg <= decode_next(op);
               jmp_reg   <= (op == OP_JMP);
            end
            ST_OPRD,
            ST_WRITE:  if (mem_ack) state_reg <= done_next;
            ST_EXEC:   state_reg <= done_next;
            ST_HALTED: state_reg <= ST_HALTED;
`ifdef CPU_SEQ_STEP_EN
            ST_PAUSE:  if (step || !dbg_en) state_reg <= ST_FETCH;
`endif
            default:   state_reg <= ST_IDLE;
         endcase
      end
   end

   // Strobes come from the registered state; rst forces them low in the same cycle.
   always_comb begin
      mem_req    = 1'b0;
      mem_we     = 1'b0;
      addr_sel   = ADDR_PC;
      ir_ld      = 1'b0;
      pc_inc     = 1'b0;
      pc_ld      = 1'b0;
      ac_ld      = 1'b0;
      instr_done = 1'b0;
      halt       = 1'b0;
      bus_err    = 1'b0;
      if (!rst) begin
         bus_err = bus_err_reg;
         case (state_reg)
            ST_FETCH: begin
               mem_req  = 1'b1;
               addr_sel = ADDR_PC;
               ir_ld    = mem_ack;
            end
            ST_DECODE: pc_inc = decode_pc_inc(op);
            ST_OPRD: begin
               mem_req    = 1'b1;
               addr_sel   = ADDR_OPR;
               ac_ld      = mem_ack;
               instr_done = mem_ack;
            end
            ST_WRITE: begin
               mem_req    = 1'b1;
               mem_we     = 1'b1;
               addr_sel   = ADDR_OPR;
               instr_done = mem_ack;
            end
            ST_EXEC: begin
               pc_inc     = !jmp_reg && ac_zero;
               pc_ld      = jmp_reg;
               instr_done = 1'b1;
            end
            ST_HALTED: halt = 1'b1;
            default: ;
         endcase
      end
   end

endmodule
